// File: rtl/sequence_mem_if.sv
// sequence_mem_if -- bundle of the producer, replay and check signals of
// sequence_mem.
//   master : drives ready/value/clear, play_start/play_ack,
//            chk_start/chk_valid/chk_value; observes everything else.
//   slave  : the sequence memory itself.
// DEPTH must match the DEPTH of the sequence_mem instance it connects to.
interface sequence_mem_if #(
  parameter int DEPTH = 32
);
  localparam int AW = $clog2(DEPTH);

  // producer side
  logic          ready;
  logic [1:0]    value;
  logic          clear;
  // replay side
  logic          play_start;
  logic          play_ack;
  logic          play_valid;
  logic [1:0]    play_value;
  logic [AW-1:0] play_index;
  // check side
  logic          chk_start;
  logic          chk_valid;
  logic [1:0]    chk_value;
  // status and single-cycle pulses
  logic [AW:0]   length;
  logic          full;
  logic          busy;
  logic          play_done;
  logic          match;
  logic          mismatch;
  logic          round_done;
  logic          drop;

  modport master (
    output ready, value, clear, play_start, play_ack,
           chk_start, chk_valid, chk_value,
    input  play_valid, play_value, play_index, length, full, busy,
           play_done, match, mismatch, round_done, drop
  );

  modport slave (
    input  ready, value, clear, play_start, play_ack,
           chk_start, chk_valid, chk_value,
    output play_valid, play_value, play_index, length, full, busy,
           play_done, match, mismatch, round_done, drop
  );
endinterface

// File: rtl/sequence_mem.sv
// sequence_mem -- colour-sequence store for a memory game.
// Colours are appended while idle, can be replayed one entry per play_ack,
// or compared one entry per player press (chk_valid).
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sequence_mem_if.slave (producer, replay, check, status, pulses)
// Memory contents survive clear and reset is not applied to them; only the
// length and pointers are cleared.
module sequence_mem #(
  parameter int DEPTH = 32
) (
  input logic           clk,
  input logic           rst,
  sequence_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, PLAY, CHECK} state_t;

  state_t        state;
  logic [1:0]    mem [DEPTH];
  logic [LW-1:0] length;
  logic [AW-1:0] play_index;
  logic [AW-1:0] pointer;
  logic          play_done;
  logic          match;
  logic          mismatch;
  logic          round_done;
  logic          drop;

  logic          full;
  logic          busy;
  logic          append;
  logic          play_last;
  logic          chk_last;
  logic          chk_hit;

  assign full   = (length == LW'(DEPTH));
  assign busy   = (state != IDLE);
  assign append = (state == IDLE) && bus.ready && !full && !bus.clear;

  // "index is length-1" written as index+1 == length so it cannot underflow
  assign play_last = ({1'b0, play_index} + LW'(1)) == length;
  assign chk_last  = ({1'b0, pointer} + LW'(1)) == length;
  assign chk_hit   = (bus.chk_value == mem[pointer]);

  // Storage: write while idle, asynchronous read so play_value follows
  // play_index in the same cycle.
  always_ff @(posedge clk) begin
    if (append) begin
      mem[length[AW-1:0]] <= bus.value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      length     <= '0;
      play_index <= '0;
      pointer    <= '0;
      play_done  <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      round_done <= 1'b0;
      drop       <= 1'b0;
    end else begin
      play_done  <= 1'b0;
      match      <= 1'b0;
      mismatch   <= 1'b0;
      round_done <= 1'b0;
      // a producer strobe that cannot be stored is reported, unless clear
      // discards it anyway
      drop       <= bus.ready && (full || busy) && !bus.clear;

      if (bus.clear) begin
        state      <= IDLE;
        length     <= '0;
        play_index <= '0;
        pointer    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (append) begin
              length <= length + LW'(1);
            end
            // start qualification uses the length before any same-cycle append
            if (bus.play_start && (length != '0)) begin
              state      <= PLAY;
              play_index <= '0;
            end else if (bus.chk_start && (length != '0)) begin
              state   <= CHECK;
              pointer <= '0;
            end
          end
          PLAY: begin
            if (bus.play_ack) begin
              if (play_last) begin
                state      <= IDLE;
                play_index <= '0;
                play_done  <= 1'b1;
              end else begin
                play_index <= play_index + AW'(1);
              end
            end
          end
          CHECK: begin
            if (bus.chk_valid) begin
              if (chk_hit) begin
                match <= 1'b1;
                if (chk_last) begin
                  round_done <= 1'b1;
                  state      <= IDLE;
                  pointer    <= '0;
                end else begin
                  pointer <= pointer + AW'(1);
                end
              end else begin
                mismatch <= 1'b1;
                state    <= IDLE;
                pointer  <= '0;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.play_valid = (state == PLAY);
  assign bus.play_value = mem[play_index];
  assign bus.play_index = play_index;
  assign bus.length     = length;
  assign bus.full       = full;
  assign bus.busy       = busy;
  assign bus.play_done  = play_done;
  assign bus.match      = match;
  assign bus.mismatch   = mismatch;
  assign bus.round_done = round_done;
  assign bus.drop       = drop;
endmodule

// File: doc/sequence_mem.md
SEQUENCE_MEM -- requirements
Module: sequence_mem

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk is the clock and rst is the reset; the polarity and synchronicity are fixed.
REQ-002 DEPTH SHALL be a parameter, default 32, giving the maximum number of stored colour entries (power of two, 4..64).
REQ-003 clk input 1: system clock; all state changes on the rising edge.
REQ-004 rst input 1: asynchronous active-high reset.
REQ-005 ready input 1: producer strobe; value is valid in any cycle where ready=1.
REQ-006 value input 2: colour code 0..3, representing game colours 1..4.
REQ-007 clear input 1: synchronous request to empty the sequence and return to IDLE.
REQ-008 play_start input 1: request to replay the stored sequence.
REQ-009 play_ack input 1: the display has consumed the current play_value.
REQ-010 play_valid output 1: play_value and play_index are valid.
REQ-011 play_value output 2: stored colour at play_index.
REQ-012 play_index output clog2(DEPTH): index of the entry being replayed.
REQ-013 chk_start input 1: request to start checking player input against the sequence.
REQ-014 chk_valid input 1: player pressed a button this cycle.
REQ-015 chk_value input 2: colour the player pressed.
REQ-016 length output clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
REQ-017 full output 1: length==DEPTH.
REQ-018 busy output 1: the block is in PLAY or CHECK.
REQ-019 play_done, match, mismatch, round_done and drop output 1 each: single-cycle pulses.

Function
REQ-020 States SHALL be IDLE, PLAY and CHECK.
REQ-021 Append rule: in IDLE, when ready=1 and full=0, value SHALL be written at address length, and length SHALL increment on the same edge.
REQ-022 Drop rule: ready=1 while full=1 or busy=1 SHALL NOT write, SHALL leave length unchanged, and SHALL pulse drop the next cycle.
REQ-023 IDLE to PLAY: play_start=1 with length>0 SHALL move to PLAY and set play_index=0; play_start with length=0 SHALL be ignored.
REQ-024 PLAY outputs: play_valid=1 throughout PLAY; play_value SHALL equal mem[play_index] combinationally, with zero-cycle read latency.
REQ-025 PLAY advance: play_ack=1 SHALL increment play_index.
REQ-026 PLAY completion: play_ack on index length-1 SHALL return to IDLE, drop play_valid, and pulse play_done for one cycle.
REQ-027 IDLE to CHECK: chk_start=1 with length>0 SHALL move to CHECK with the check pointer at 0.
REQ-028 CHECK compare: each chk_valid=1 SHALL compare chk_value with mem[pointer].
REQ-029 CHECK match: equal values SHALL pulse match and increment the pointer.
REQ-030 CHECK end of round: a match on the last entry SHALL also pulse round_done and return to IDLE.
REQ-031 CHECK mismatch: unequal values SHALL pulse mismatch and return to IDLE immediately, with length unchanged.
REQ-032 Pulse timing: match, mismatch, round_done and play_done SHALL assert on the cycle after the qualifying input edge.
REQ-033 Priority: clear SHALL win over every other input in any state; length becomes 0 and the state becomes IDLE next cycle.
REQ-034 Start priority: play_start and chk_start asserted together in IDLE SHALL select PLAY.
REQ-035 Busy-state starts: play_start or chk_start while busy SHALL be ignored.
REQ-036 Inputs outside their state: chk_valid outside CHECK and play_ack outside PLAY SHALL be ignored.
REQ-037 Pointer width: pointers SHALL never exceed length-1 and SHALL NOT wrap.
REQ-038 length SHALL saturate at DEPTH.
REQ-039 Memory contents SHALL persist across PLAY and CHECK and SHALL NOT be cleared by clear; only length is cleared.

Reset
REQ-040 rst=1 SHALL immediately force state IDLE, length=0, play_index=0, and pointer=0.
REQ-041 rst=1 SHALL also immediately force play_valid, busy and all pulses to 0; memory contents are don't-care.
REQ-042 Reset asserted mid-PLAY or mid-CHECK SHALL abort with no play_done, round_done or mismatch pulse.

Verification
REQ-043 Append and play: append 2,0,3 via ready pulses -> length=3; play_start then play_ack each cycle -> play_value 2,0,3 on play_index 0,1,2, play_done one cycle after the third ack.
REQ-044 Check pass and fail: with sequence 1,1,2, chk_start then presses 1,1,2 -> match x3 and round_done; repeat with 1,3 -> match then mismatch and IDLE, length=3.
REQ-045 Full and drop: DEPTH=4, five ready pulses -> length=4, full=1, fifth pulse gives drop and no write; a ready pulse during PLAY gives drop, length unchanged.
REQ-046 Clear priority: clear together with ready in IDLE -> length=0 with no write; clear mid-CHECK -> IDLE with no mismatch or round_done.
REQ-047 Async reset: rst asserted between clock edges during PLAY -> play_valid=0 and length=0 before the next edge; play_start on an empty sequence -> stays IDLE.
